// File: rtl/dcache_pkg.sv
// dcache_pkg: field widths and FSM state encoding shared by the data cache
package dcache_pkg;
  localparam int TAG_W = 25;
  localparam int IDX_W = 3;
  localparam int OFF_W = 2;
  localparam int LINE_W = 128;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage, one write port, asynchronous read
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic              wdirty,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [LINE_W-1:0] wline,
  output logic              rvalid,
  output logic              rdirty,
  output logic [TAG_W-1:0]  rtag,
  output logic [LINE_W-1:0] rline
);
  logic [NUM_BLOCKS-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [NUM_BLOCKS];
  logic [WORDS_PER_BLOCK*32-1:0] data [NUM_BLOCKS];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else if (we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= wdirty;
      tags[idx] <= wtag;
      data[idx] <= wline;
    end
  end
  assign rvalid = valid[idx];
  assign rdirty = dirty[idx];
  assign rtag = tags[idx];
  assign rline = data[idx];
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back/write-allocate data cache with 0-cycle read hits
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [29:0]       proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [27:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  state_t state, nxt;
  logic [TAG_W-1:0] tag, rtag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [LINE_W-1:0] rline, wline;
  logic rvalid, rdirty, req, hit, we;
  assign tag = proc_addr[29:5];
  assign idx = proc_addr[4:2];
  assign off = proc_addr[1:0];
  assign req = proc_read | proc_write;
  assign hit = req && state == IDLE && rvalid && rtag == tag;
  assign proc_stall = state != IDLE || (req && !hit);
  assign proc_rdata = hit && !proc_write ? rline[{off, 5'd0} +: 32] : '0;
  assign we = (hit && proc_write) || (state == ALLOCATE && mem_ready);
  always_comb begin
    wline = rline;
    wline[{off, 5'd0} +: 32] = proc_wdata;
    wline = state == ALLOCATE ? mem_rdata : wline;
  end
  always_comb begin
    nxt = state == IDLE ? (req && !hit ? (rvalid && rdirty ? WRITEBACK : ALLOCATE) : IDLE)
        : !mem_ready ? state
        : state == WRITEBACK ? ALLOCATE : IDLE;
  end
  // request lines are registered copies of the next state, so they drop the cycle after mem_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      mem_read <= nxt == ALLOCATE;
      mem_write <= nxt == WRITEBACK;
      if (state == IDLE && nxt == WRITEBACK) begin
        mem_addr <= {rtag, idx};
        mem_wdata <= rline;
      end else if (state != ALLOCATE && nxt == ALLOCATE) begin
        mem_addr <= proc_addr[29:2];
      end
    end
  end
  dcache_array #(.NUM_BLOCKS(NUM_BLOCKS), .WORDS_PER_BLOCK(WORDS_PER_BLOCK)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .idx(idx),
    .we(we),
    .wdirty(state == IDLE),
    .wtag(tag),
    .wline(wline),
    .rvalid(rvalid),
    .rdirty(rdirty),
    .rtag(rtag),
    .rline(rline)
  );
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed vector table, reset-abort sequence and randomized accesses vs a flat-memory model
module tb_dcache;
  logic clk = 0, rst_n = 0, proc_read = 0, proc_write = 0, mem_ready = 0;
  logic [29:0] proc_addr = 0;
  logic [31:0] proc_wdata = 0, proc_rdata;
  logic proc_stall, mem_read, mem_write;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata = 0;
  int checks = 0, errors = 0, lat = 3, spur_req = 0;
  logic [127:0] mem [logic [27:0]];
  logic [31:0] gold [logic [29:0]];
  logic [24:0] mtag [8];
  bit mval [8], mdirty [8];

  typedef struct {
    bit rd; bit wr; logic [29:0] a; logic [31:0] wd;
    int stalls; bit wb; logic [27:0] wb_addr; logic [31:0] wb_w1;
    logic [27:0] rd_addr; logic [31:0] rdata;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  dcache dut (
    .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [31:0] init_word(logic [29:0] a);
    return a == 30'h10 ? 32'h11111111 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [127:0] mem_line(logic [27:0] la);
    logic [127:0] l;
    if (mem.exists(la)) return mem[la];
    for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word({la, i[1:0]});
    return l;
  endfunction

  function automatic logic [31:0] gold_word(logic [29:0] a);
    logic [127:0] l;
    if (gold.exists(a)) return gold[a];
    l = mem_line(a[29:2]);
    return l[32*a[1:0] +: 32];
  endfunction

  function automatic logic [127:0] gold_line(logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = gold_word({la, i[1:0]});
    return l;
  endfunction

  // memory: answers each request after lat+1 cycles with a one-cycle mem_ready
  initial begin
    int cnt = 0, spur_ack = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready) begin mem_ready = 0; cnt = 0; end
      if (mem_read || mem_write) begin
        cnt++;
        if (cnt > lat) begin
          mem_ready = 1;
          if (mem_write) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem_line(mem_addr);
        end
      end else begin
        cnt = 0;
        if (spur_req != spur_ack) begin spur_ack = spur_req; mem_ready = 1; end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] wd,
                           output int stalls, output bit wb, output logic [27:0] wb_addr,
                           output logic [127:0] wb_data, output logic [27:0] rd_addr,
                           output logic [31:0] rdata);
    bit prd = 0, pwr = 0, prdy = 0, done = 0;
    logic [27:0] pa = 0;
    logic [127:0] pd = 0;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    stalls = 0; wb = 0; wb_addr = 0; wb_data = 0; rd_addr = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      chk("rd_wr_exclusive", {mem_read, mem_write} == 2'b11, 0);
      if (mem_read && prd && !prdy) chk("fill_addr_stable", mem_addr, pa);
      if (mem_write && pwr && !prdy) begin
        chk("wb_addr_stable", mem_addr, pa);
        chk("wb_data_stable", mem_wdata, pd);
      end
      if (mem_write && !wb) begin wb = 1; wb_addr = mem_addr; wb_data = mem_wdata; end
      if (mem_read && !prd) rd_addr = mem_addr;
      prd = mem_read; pwr = mem_write; prdy = mem_ready; pa = mem_addr; pd = mem_wdata;
      if (proc_stall) stalls++; else done = 1;
    end
    chk("stall_released", done, 1);
    rdata = proc_rdata;
    @(posedge clk); #1;
    proc_read = 0; proc_write = 0;
  endtask

  task automatic idle_cycles();
    spur_req++;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stall", proc_stall, 0);
      chk("idle_rdata", proc_rdata, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; proc_read = 0; proc_write = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin mval[i] = 0; mdirty[i] = 0; mtag[i] = 0; end
    gold.delete();
  endtask

  initial begin
    int st, exp_st;
    bit wb, seen, hit, ewb, rd, wr;
    logic [27:0] wa, ra;
    logic [127:0] wdat, vline;
    logic [31:0] rdat, wd;
    logic [29:0] a;
    logic [2:0] ix;
    tbl[0]  = '{1, 0, 30'h10,  0,            5, 0, 0,      0,            28'h4,  32'h11111111};
    tbl[1]  = '{0, 1, 30'h11,  32'hDEADBEEF, 0, 0, 0,      0,            0,      0};
    tbl[2]  = '{1, 0, 30'h11,  0,            0, 0, 0,      0,            0,      32'hDEADBEEF};
    tbl[3]  = '{1, 0, 30'h91,  0,            9, 1, 28'h4,  32'hDEADBEEF, 28'h24, 32'h0091FF6E};
    tbl[4]  = '{1, 0, 30'h10,  0,            5, 0, 0,      0,            28'h4,  32'h11111111};
    tbl[5]  = '{1, 0, 30'h11,  0,            0, 0, 0,      0,            0,      32'hDEADBEEF};
    tbl[6]  = '{1, 1, 30'h12,  32'hCAFEF00D, 0, 0, 0,      0,            0,      0};
    tbl[7]  = '{1, 0, 30'h12,  0,            0, 0, 0,      0,            0,      32'hCAFEF00D};
    tbl[8]  = '{1, 0, 30'h3,   0,            5, 0, 0,      0,            28'h0,  32'h0003FFFC};
    tbl[9]  = '{0, 1, 30'h2A0, 32'h12345678, 5, 0, 0,      0,            28'hA8, 0};
    tbl[10] = '{1, 0, 30'h2A0, 0,            0, 0, 0,      0,            0,      32'h12345678};
    tbl[11] = '{1, 0, 30'h3,   0,            9, 1, 28'hA8, 32'h02A1FD5E, 28'h0,  32'h0003FFFC};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata", proc_rdata, 0);
    @(posedge clk); #1 rst_n = 1;

    foreach (tbl[i]) begin
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, st, wb, wa, wdat, ra, rdat);
      chk($sformatf("v%0d_stalls", i), st, tbl[i].stalls);
      chk($sformatf("v%0d_writeback", i), wb, tbl[i].wb);
      if (tbl[i].wb) begin
        chk($sformatf("v%0d_wb_addr", i), wa, tbl[i].wb_addr);
        chk($sformatf("v%0d_wb_word1", i), wdat[63:32], tbl[i].wb_w1);
      end
      if (tbl[i].stalls > 0) chk($sformatf("v%0d_fill_addr", i), ra, tbl[i].rd_addr);
      if (tbl[i].rd && !tbl[i].wr) chk($sformatf("v%0d_rdata", i), rdat, tbl[i].rdata);
    end
    idle_cycles();

    // reset during a fill: the line must stay invalid
    lat = 20;
    proc_read = 1; proc_addr = 30'h200;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = mem_read; end
    chk("abort_fill_started", seen, 1);
    @(posedge clk); #1 rst_n = 0; proc_read = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_stall", proc_stall, 0);
    chk("abort_mem_addr", mem_addr, 0);
    @(posedge clk); #1 lat = 3;
    do_access(1, 0, 30'h200, 0, st, wb, wa, wdat, ra, rdat);
    chk("abort_remiss_stalls", st, 5);
    chk("abort_remiss_wb", wb, 0);
    chk("abort_remiss_rdata", rdat, 32'h0200FDFF);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      ix = a[4:2];
      case ($urandom_range(0, 3))
        0, 1: begin rd = 1; wr = 0; end
        2: begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      wd = $urandom;
      lat = $urandom_range(0, 3);
      hit = mval[ix] && mtag[ix] == a[29:5];
      ewb = !hit && mval[ix] && mdirty[ix];
      exp_st = hit ? 0 : (ewb ? lat + 1 : 0) + lat + 2;
      vline = gold_line({mtag[ix], ix});
      do_access(rd, wr, a, wd, st, wb, wa, wdat, ra, rdat);
      chk($sformatf("r%0d_stalls", n), st, exp_st);
      chk($sformatf("r%0d_writeback", n), wb, ewb);
      if (ewb) begin
        chk($sformatf("r%0d_wb_addr", n), wa, {mtag[ix], ix});
        chk($sformatf("r%0d_wb_line", n), wdat, vline);
      end
      if (!hit) chk($sformatf("r%0d_fill_addr", n), ra, a[29:2]);
      if (rd && !wr) chk($sformatf("r%0d_rdata", n), rdat, gold_word(a));
      if (!hit) begin mval[ix] = 1; mtag[ix] = a[29:5]; mdirty[ix] = 0; end
      if (wr) begin gold[a] = wd; mdirty[ix] = 1; end
      if ($urandom_range(0, 7) == 0) idle_cycles();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
